// File: rtl/reflet_bridge_pkg.sv
// Shared definitions for the reflet peripheral bridge: FSM state encoding,
// derived-width helpers and the byte order used when serialising words.
package reflet_bridge_pkg;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Bytes are issued lowest-significance first.
    localparam bit LITTLE_ENDIAN = 1'b1;

    // Number of byte cycles in a full-word access.
    function automatic int nbytes(input int wordsize);
        return wordsize / 8;
    endfunction

    // Width of a peripheral register offset; at least one bit so that a
    // single-register window still has a legal port.
    function automatic int off_w(input int num_slots, input int slot_size);
        int w;
        w = $clog2(num_slots * slot_size);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reflet_slot_decoder.sv
// Maps a byte offset (relative to the window base) onto an in-window flag and
// a one-hot slot select. Out-of-window offsets select no slot.
module reflet_slot_decoder #(
    parameter int w         = 8,
    parameter int num_slots = 8,
    parameter int slot_size = 8
) (
    input  logic [w-1:0]         off,
    output logic                 in_window,
    output logic [num_slots-1:0] slot_sel
);

    localparam int WIN_SIZE  = num_slots * slot_size;
    localparam int SLOT_BITS = $clog2(slot_size);

    logic [w-1:0] slot_idx;

    // Window membership and one-hot slot select for the given offset.
    always_comb begin
        in_window = (off < w'(WIN_SIZE));
        slot_idx  = off >> SLOT_BITS;
        slot_sel  = '0;
        for (int i = 0; i < num_slots; i++) begin
            slot_sel[i] = in_window && (slot_idx == w'(i));
        end
    end

endmodule

// File: rtl/reflet_periph_bridge.sv
// Bridges a wordsize-wide CPU data port onto an 8-bit peripheral bus.
// Each CPU access is serialised into byte cycles over a window of num_slots
// peripheral slots starting at base_addr; out-of-window requests end at once
// with err. Optional macro REFLET_BRIDGE_WAIT_EN adds a p_wait input that
// stretches the current byte cycle.
//
// Handshake: req is a single-cycle strobe, only accepted in IDLE with enable
// high; ready pulses for exactly one cycle when the access completes, and
// data_out is valid in that cycle and held until the next read or error.
module reflet_periph_bridge
    import reflet_bridge_pkg::*;
#(
    parameter int                          wordsize       = 16,
    parameter int                          base_addr_size = 16,
    parameter logic [base_addr_size-1:0]   base_addr      = 16'hFF00,
    parameter int                          num_slots      = 8,
    parameter int                          slot_size      = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     req,
    input  logic [base_addr_size-1:0]                addr,
    input  logic [wordsize-1:0]                      data_in,
    input  logic                                     write_en,
    input  logic                                     byte_mode,
    output logic [wordsize-1:0]                      data_out,
    output logic                                     ready,
    output logic                                     err,
    output logic [off_w(num_slots, slot_size)-1:0]   p_addr,
    output logic [7:0]                               p_data_out,
    input  logic [7:0]                               p_data_in,
    output logic                                     p_enable,
    output logic                                     p_write_en,
    output logic [num_slots-1:0]                     p_slot_sel,
    output logic [1:0]                               dbg_state
`ifdef REFLET_BRIDGE_WAIT_EN
    ,
    input  logic                                     p_wait
`endif
);

    localparam int NBYTES = nbytes(wordsize);
    localparam int OFF_W  = off_w(num_slots, slot_size);
    localparam int REQ_W  = base_addr_size + 1;
    localparam int BYTE_W = OFF_W + 4;

    state_t                state_q, state_d;
    logic [OFF_W-1:0]      off_q;
    logic [wordsize-1:0]   wdata_q;
    logic [wordsize-1:0]   acc_q;
    logic [wordsize-1:0]   data_out_q;
    logic                  wr_q;
    logic [3:0]            idx_q;
    logic [3:0]            n_q;
    logic [3:0]            lane;
    logic                  stall;
    logic                  accept;

    logic [REQ_W-1:0]      req_off;
    logic                  req_in_win;
    logic [num_slots-1:0]  req_sel_unused;

    logic [BYTE_W-1:0]     byte_off;
    logic                  byte_in_win;
    logic [num_slots-1:0]  byte_sel;
    logic [7:0]            wr_byte;
    logic [7:0]            rd_byte;

`ifdef REFLET_BRIDGE_WAIT_EN
    assign stall = p_wait;
`else
    assign stall = 1'b0;
`endif

    // One extra bit so that an address below base_addr wraps to a large
    // offset and fails the window check.
    assign req_off  = {1'b0, addr} - {1'b0, base_addr};
    assign byte_off = BYTE_W'(off_q) + BYTE_W'(idx_q);
    assign lane     = LITTLE_ENDIAN ? idx_q : (4'(NBYTES - 1) - idx_q);
    assign accept   = (state_q == IDLE) && req && enable && req_in_win;
    assign dbg_state = state_q;

    reflet_slot_decoder #(
        .w         (REQ_W),
        .num_slots (num_slots),
        .slot_size (slot_size)
    ) u_req_dec (
        .off       (req_off),
        .in_window (req_in_win),
        .slot_sel  (req_sel_unused)
    );

    reflet_slot_decoder #(
        .w         (BYTE_W),
        .num_slots (num_slots),
        .slot_size (slot_size)
    ) u_byte_dec (
        .off       (byte_off),
        .in_window (byte_in_win),
        .slot_sel  (byte_sel)
    );

    // Lane select of the outgoing write byte and masking of the read byte.
    always_comb begin
        wr_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (lane == 4'(b)) begin
                wr_byte = wdata_q[b*8 +: 8];
            end
        end
        rd_byte = byte_in_win ? p_data_in : 8'h00;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and all bus/CPU-side outputs.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        err        = 1'b0;
        data_out   = data_out_q;
        p_addr     = '0;
        p_data_out = 8'h00;
        p_enable   = 1'b0;
        p_write_en = 1'b0;
        p_slot_sel = '0;
        case (state_q)
            IDLE: begin
                if (req && enable) begin
                    state_d = req_in_win ? XFER : ERR;
                end
            end
            XFER: begin
                p_addr     = byte_off[OFF_W-1:0];
                p_data_out = wr_byte;
                p_enable   = byte_in_win;
                p_write_en = wr_q && byte_in_win;
                p_slot_sel = byte_sel;
                if (!stall && (idx_q == n_q - 4'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                if (!wr_q) begin
                    data_out = acc_q;
                end
                state_d = IDLE;
            end
            ERR: begin
                ready    = 1'b1;
                err      = 1'b1;
                data_out = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latching, byte index, read accumulation and held read result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            off_q      <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            wr_q       <= 1'b0;
            idx_q      <= 4'd0;
            n_q        <= 4'd0;
        end else begin
            if (accept) begin
                off_q   <= req_off[OFF_W-1:0];
                wdata_q <= data_in;
                wr_q    <= write_en;
                n_q     <= byte_mode ? 4'd1 : 4'(NBYTES);
                idx_q   <= 4'd0;
                acc_q   <= '0;
            end
            if ((state_q == XFER) && !stall) begin
                idx_q <= idx_q + 4'd1;
                if (!wr_q) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (lane == 4'(b)) begin
                            acc_q[b*8 +: 8] <= rd_byte;
                        end
                    end
                end
            end
            if ((state_q == DONE) || (state_q == ERR)) begin
                data_out_q <= data_out;
            end
        end
    end

endmodule
